// File: rtl/sc_frame_sync_ctrl.sv
// Schmidl-Cox frame sequencer: finds the metric plateau, skips an offset,
// then gates one frame of the lockstep payload stream to the output with tlast.
module sc_frame_sync_ctrl #(
  parameter int FFT_SIZE = 16,
  parameter int MW       = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [MW-1:0]    cfg_threshold,
  input  logic [CNT_W-1:0] cfg_min_plat,
  input  logic [CNT_W-1:0] cfg_skip_len,
  input  logic [CNT_W-1:0] cfg_frame_len,
  input  logic [MW-1:0]    m_tdata,
  input  logic             m_tvalid,
  output logic             m_tready,
  input  logic [31:0]      i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [31:0]      o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             frame_det,
  output logic [MW-1:0]    peak_metric,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {SEARCH = 2'd0, PLATEAU = 2'd1, SKIP = 2'd2, PASS = 2'd3} state_t;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] plat_q, plat_d, skip_q, skip_d, pass_q, pass_d;
  logic [MW-1:0]    run_pk_q, run_pk_d, pk_q, pk_d, thr_s_q, thr_s_d;
  logic [CNT_W-1:0] min_s_q, min_s_d, skp_s_q, skp_s_d, len_s_q, len_s_d;
  logic             det_q, det_d;

  logic             both, go, last, accept;
  logic [CNT_W-1:0] plat_inc;
  logic [MW-1:0]    pk_max, acc_pk;
  logic             unused_tlast;

  assign unused_tlast = i_tlast;
  assign both     = m_tvalid & i_tvalid;
  assign go       = (st_q == PASS) ? (both & o_tready) : both;
  assign last     = (pass_q == len_s_q - CNT_W'(1));
  assign plat_inc = plat_q + CNT_W'(1);
  assign pk_max   = (m_tdata > run_pk_q) ? m_tdata : run_pk_q;

  always_comb begin
    st_d     = st_q;
    plat_d   = plat_q;
    skip_d   = skip_q;
    pass_d   = pass_q;
    run_pk_d = run_pk_q;
    pk_d     = pk_q;
    thr_s_d  = thr_s_q;
    min_s_d  = min_s_q;
    skp_s_d  = skp_s_q;
    len_s_d  = len_s_q;
    det_d    = 1'b0;
    accept   = 1'b0;
    acc_pk   = run_pk_q;
    if (go) begin
      case (st_q)
        SEARCH: if (m_tdata >= cfg_threshold) begin
          st_d     = PLATEAU;
          plat_d   = CNT_W'(1);
          run_pk_d = m_tdata;
          thr_s_d  = cfg_threshold;
          min_s_d  = (cfg_min_plat == '0) ? CNT_W'(1) : cfg_min_plat;
          skp_s_d  = cfg_skip_len;
          len_s_d  = (cfg_frame_len == '0) ? CNT_W'(1) : cfg_frame_len;
        end
        PLATEAU: begin
          if (m_tdata >= thr_s_q) begin
            plat_d   = plat_inc;
            run_pk_d = pk_max;
            // Plateau length is capped at one symbol; hitting the cap ends it.
            if (plat_inc == CNT_W'(FFT_SIZE)) begin
              accept = 1'b1;
              acc_pk = pk_max;
            end
          end else if (plat_q >= min_s_q) begin
            accept = 1'b1;
          end else begin
            st_d = SEARCH;
          end
        end
        SKIP: begin
          skip_d = skip_q - CNT_W'(1);
          if (skip_q == CNT_W'(1)) begin
            st_d   = PASS;
            pass_d = '0;
          end
        end
        default: begin
          pass_d = pass_q + CNT_W'(1);
          if (last) st_d = SEARCH;
        end
      endcase
    end
    if (accept) begin
      pk_d   = acc_pk;
      det_d  = 1'b1;
      skip_d = skp_s_q;
      pass_d = '0;
      st_d   = (skp_s_q == '0) ? PASS : SKIP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      st_q     <= SEARCH;
      plat_q   <= '0;
      skip_q   <= '0;
      pass_q   <= '0;
      run_pk_q <= '0;
      pk_q     <= '0;
      thr_s_q  <= '0;
      min_s_q  <= '0;
      skp_s_q  <= '0;
      len_s_q  <= '0;
      det_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      plat_q   <= plat_d;
      skip_q   <= skip_d;
      pass_q   <= pass_d;
      run_pk_q <= run_pk_d;
      pk_q     <= pk_d;
      thr_s_q  <= thr_s_d;
      min_s_q  <= min_s_d;
      skp_s_q  <= skp_s_d;
      len_s_q  <= len_s_d;
      det_q    <= det_d;
    end
  end

  assign m_tready    = go;
  assign i_tready    = go;
  assign o_tdata     = i_tdata;
  assign o_tvalid    = (st_q == PASS) & both;
  assign o_tlast     = (st_q == PASS) & last;
  assign frame_det   = det_q;
  assign peak_metric = pk_q;
  assign state       = st_q;
endmodule

// File: tb/tb_sc_frame_sync_ctrl.sv
// Scoreboard bench for sc_frame_sync_ctrl: a list-scanning reference model
// predicts frames and detections; a monitor compares whatever the DUT emits.
module tb_sc_frame_sync_ctrl;
  localparam int FFT = 16;
  localparam int MW  = 32;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          reset, clear;
  logic [MW-1:0] cfg_threshold;
  logic [CW-1:0] cfg_min_plat, cfg_skip_len, cfg_frame_len;
  logic [MW-1:0] m_tdata;
  logic          m_tvalid, m_tready;
  logic [31:0]   i_tdata;
  logic          i_tlast, i_tvalid, i_tready;
  logic [31:0]   o_tdata;
  logic          o_tlast, o_tvalid, o_tready;
  logic          frame_det;
  logic [MW-1:0] peak_metric;
  logic [1:0]    state;

  always #5 clk = ~clk;

  sc_frame_sync_ctrl #(.FFT_SIZE(FFT), .MW(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .cfg_threshold(cfg_threshold), .cfg_min_plat(cfg_min_plat),
    .cfg_skip_len(cfg_skip_len), .cfg_frame_len(cfg_frame_len),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .frame_det(frame_det), .peak_metric(peak_metric), .state(state)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus: one entry per lockstep beat, with the config visible while it is presented.
  logic [31:0] mets[$], pays[$], thr_at[$];
  int          min_at[$], skp_at[$], fl_at[$];
  logic [32:0] exp_q[$];
  logic [31:0] det_exp[$];
  logic [31:0] cur_thr;
  int          cur_min, cur_skp, cur_fl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic add(input logic [31:0] m, input int rep);
    for (int k = 0; k < rep; k++) begin
      mets.push_back(m);
      pays.push_back($urandom);
      thr_at.push_back(cur_thr);
      min_at.push_back(cur_min);
      skp_at.push_back(cur_skp);
      fl_at.push_back(cur_fl);
    end
  endtask

  // Scan beats [lo,hi): find each plateau, decide acceptance, list the frame's payload.
  // clr: a clear lands on beat hi-1, so an acceptance on that beat never happens.
  task automatic model_seg(input int lo, input int hi, input bit clr);
    int i, j, len, end_i, fs, fl, minp;
    logic [31:0] thr, pk;
    bit done;
    i = lo;
    done = 0;
    while (i < hi && !done) begin
      if (mets[i] < thr_at[i]) i++;
      else begin
        thr  = thr_at[i];
        minp = (min_at[i] == 0) ? 1 : min_at[i];
        fl   = (fl_at[i] == 0) ? 1 : fl_at[i];
        pk = 0; len = 0; j = i; end_i = -1;
        while (j < hi && len < FFT && mets[j] >= thr) begin
          if (mets[j] > pk) pk = mets[j];
          len++; j++;
        end
        if (len == FFT) end_i = j - 1;
        else if (j >= hi) done = 1;
        else if (len >= minp) end_i = j;
        else i = j + 1;
        if (end_i >= 0) begin
          if (clr && end_i == hi - 1) done = 1;
          else begin
            det_exp.push_back(pk);
            fs = end_i + 1 + skp_at[i];
            for (int k = 0; k < fl; k++)
              if (fs + k < hi) exp_q.push_back({(k == fl - 1), pays[fs + k]});
            i = fs + fl;
          end
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands out a beat or a detection.
  initial begin
    logic [32:0] e;
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_beat: got data %0h with nothing expected", o_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("o_tdata", {32'd0, o_tdata}, {32'd0, e[31:0]});
          chk("o_tlast", {63'd0, o_tlast}, {63'd0, e[32]});
        end
      end
      if (frame_det) begin
        if (det_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_det: got peak %0h with no detection expected", peak_metric);
        end else begin
          p = det_exp.pop_front();
          chk("peak_metric", {32'd0, peak_metric}, {32'd0, p});
        end
      end
      if (!(m_tvalid && i_tvalid))
        chk("ready_single", {62'd0, m_tready, i_tready}, 64'd0);
    end
  end

  task automatic run_phase(input string nm, input bit rnd, input int clr_idx);
    int n, idx, cyc;
    bit f, post_clr;
    n = mets.size();
    reset = 1'b0; clear = 1'b0; m_tvalid = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({nm, "_rst_state"}, {62'd0, state}, 64'd0);
    chk({nm, "_rst_vld"}, {62'd0, o_tvalid, o_tlast}, 64'd0);
    chk({nm, "_rst_det"}, {63'd0, frame_det}, 64'd0);
    chk({nm, "_rst_peak"}, {32'd0, peak_metric}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    if (clr_idx >= 0) begin
      model_seg(0, clr_idx + 1, 1'b1);
      model_seg(clr_idx + 1, n, 1'b0);
    end else model_seg(0, n, 1'b0);
    idx = 0; cyc = 0; post_clr = 0;
    while (idx < n && cyc < 4000) begin
      m_tdata       = mets[idx];
      i_tdata       = pays[idx];
      i_tlast       = 1'($urandom);
      cfg_threshold = thr_at[idx];
      cfg_min_plat  = CW'(min_at[idx]);
      cfg_skip_len  = CW'(skp_at[idx]);
      cfg_frame_len = CW'(fl_at[idx]);
      if (idx == clr_idx && !post_clr) begin
        clear = 1'b1; m_tvalid = 1'b1; i_tvalid = 1'b1; o_tready = 1'b1;
      end else begin
        clear = 1'b0;
        m_tvalid = rnd ? ($urandom_range(3) != 0) : 1'b1;
        i_tvalid = rnd ? ($urandom_range(3) != 0) : 1'b1;
        o_tready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      end
      @(negedge clk);
      if (post_clr) begin
        chk({nm, "_clr_state"}, {62'd0, state}, 64'd0);
        chk({nm, "_clr_vld"}, {63'd0, o_tvalid}, 64'd0);
        post_clr = 0;
      end
      f = m_tvalid && m_tready;
      @(posedge clk); #1;
      if (clear) post_clr = 1;
      if (f) idx++;
      cyc++;
    end
    if (idx < n) begin
      total++; bad++;
      $display("FAIL %s_timeout: consumed %0d of %0d beats", nm, idx, n);
    end
    clear = 1'b0; m_tvalid = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({nm, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_dets_left"}, 64'(det_exp.size()), 64'd0);
    exp_q.delete(); det_exp.delete();
    mets.delete(); pays.delete(); thr_at.delete();
    min_at.delete(); skp_at.delete(); fl_at.delete();
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0;
    m_tvalid = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0; i_tlast = 1'b0;
    m_tdata = '0; i_tdata = '0;
    cfg_threshold = '0; cfg_min_plat = '0; cfg_skip_len = '0; cfg_frame_len = '0;

    // basic detection with skip
    cur_thr = 100; cur_min = 3; cur_skp = 2; cur_fl = 4;
    add(0, 1); add(150, 1); add(200, 1); add(120, 1); add(50, 1);
    add(10, 2); add(7, 1); add(5, 8);
    run_phase("p1", 1'b0, -1);

    // plateau too short
    cur_thr = 100; cur_min = 3; cur_skp = 0; cur_fl = 2;
    add(0, 1); add(120, 1); add(130, 1); add(50, 8);
    run_phase("p2", 1'b1, -1);
    chk("p2_state", {62'd0, state}, 64'd0);

    // plateau length cap with no skip
    cur_thr = 100; cur_min = 3; cur_skp = 0; cur_fl = 5;
    add(10, 2);
    for (int k = 0; k < 40; k++) add(32'(100 + 3 * k), 1);
    add(0, 10);
    run_phase("p3", 1'b0, -1);

    // heavy backpressure and valid toggling, long frame
    cur_thr = 1000; cur_min = 2; cur_skp = 1; cur_fl = 8;
    add(5, 3);
    for (int k = 0; k < 4; k++) add(32'(1000 + $urandom_range(500)), 1);
    add(3, 20);
    run_phase("p4", 1'b1, -1);

    // clear on the second frame beat, then a normal detection
    cur_thr = 100; cur_min = 2; cur_skp = 1; cur_fl = 6;
    add(0, 1); add(200, 2); add(50, 1); add(0, 11);
    add(300, 1); add(250, 1); add(310, 1); add(20, 12);
    run_phase("p5", 1'b1, 6);

    // frame length changed mid-frame
    cur_thr = 100; cur_min = 1; cur_skp = 0; cur_fl = 3;
    add(0, 1); add(150, 1); add(20, 2);
    cur_fl = 5;
    add(20, 4); add(180, 1); add(190, 1); add(30, 10);
    run_phase("p6", 1'b1, -1);

    // randomized configs and metric streams
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 4; s++) begin
        cur_thr = 32'(50 + $urandom_range(100));
        cur_min = $urandom_range(4);
        cur_skp = $urandom_range(3);
        cur_fl  = $urandom_range(6);
        for (int k = 0; k < 25; k++)
          add(($urandom_range(3) == 0) ? cur_thr + 32'($urandom_range(50))
                                       : 32'($urandom_range(int'(cur_thr) - 1)), 1);
      end
      run_phase("rnd", 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
